// File: rtl/fifo_pkg.sv
// Shared defaults and constant helpers for the parametrised FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;

  // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W storage, one synchronous write port and one registered read port.
// Read data appears one cycle after rd_vld and holds otherwise; no backpressure, the caller arbitrates.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_vld,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_vld,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_dat_d;
  logic [DATA_W-1:0] rd_dat_q;

  // Array is deliberately unreset so it maps onto plain storage.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_vld) begin
      rd_dat_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with almost-full/almost-empty thresholds and synchronous flush.
// Read data and ack/err pulses are registered one cycle after the request; requests are refused (err) when full/empty/flushing.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int CNT_W    = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] d_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] d_out,
  output logic [CNT_W-1:0]  data_count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             wr_ack_d, wr_ack_q;
  logic             wr_err_d, wr_err_q;
  logic             rd_ack_d, rd_ack_q;
  logic             rd_err_d, rd_err_q;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance is judged on the registered flags, so full+rd+wr admits only the read
  // and empty+rd+wr admits only the write.
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_acc && !rd_acc) count_d = count_q + CNT_W'(1);
      if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
    end
    wr_ack_d = wr_acc;
    wr_err_d = wr_en && !wr_acc;
    rd_ack_d = rd_acc;
    rd_err_d = rd_en && !rd_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_vld  (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_dat  (d_in),
    .rd_vld  (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_dat  (d_out)
  );

  assign data_count   = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign wr_ack       = wr_ack_q;
  assign wr_err       = wr_err_q;
  assign rd_ack       = rd_ack_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at DATA_W=32, DEPTH=8 (AF_LEVEL=6, AE_LEVEL=2).
module tb_param_fifo;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        wr_en;
  logic [31:0] d_in;
  logic        rd_en;
  logic [31:0] d_out;
  logic [3:0]  data_count;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;

  int tests;
  int fails;

  param_fifo #(.DATA_W(32), .DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .wr_en        (wr_en),
    .d_in         (d_in),
    .rd_en        (rd_en),
    .d_out        (d_out),
    .data_count   (data_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then stable for sampling.
  task step;
    @(posedge clk);
    #1;
  endtask

  task idle;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  task test_reset;
    reset = 1'b1;
    idle();
    d_in = '0;
    step();
    step();
    reset = 1'b0;
    step();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", empty); end
    tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", full); end
    tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    tests++; if (data_count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", data_count); end
    tests++; if (d_out !== 32'h00000000) begin fails++; $display("FAIL reset_dout got=%h exp=00000000", d_out); end
    tests++; if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000) begin fails++; $display("FAIL reset_handshake got=%b exp=0000", {wr_ack, wr_err, rd_ack, rd_err}); end
  endtask

  task test_fill;
    int exp_cnt;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1;
      d_in  = 32'h00110011 * (i + 1);
      step();
      exp_cnt = (i < 8) ? i + 1 : 8;
      tests++; if (wr_ack !== (i < 8)) begin fails++; $display("FAIL fill_wr_ack[%0d] got=%b exp=%b", i, wr_ack, (i < 8)); end
      tests++; if (wr_err !== (i == 8)) begin fails++; $display("FAIL fill_wr_err[%0d] got=%b exp=%b", i, wr_err, (i == 8)); end
      tests++; if (data_count !== 4'(exp_cnt)) begin fails++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, data_count, exp_cnt); end
      tests++; if (almost_full !== (exp_cnt >= 6)) begin fails++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, almost_full, (exp_cnt >= 6)); end
      tests++; if (almost_empty !== (exp_cnt <= 2)) begin fails++; $display("FAIL fill_almost_empty[%0d] got=%b exp=%b", i, almost_empty, (exp_cnt <= 2)); end
    end
    idle();
    step();
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full got=%b exp=1", full); end
    tests++; if ({wr_ack, wr_err} !== 2'b00) begin fails++; $display("FAIL fill_idle_pulses got=%b exp=00", {wr_ack, wr_err}); end
  endtask

  task test_drain;
    for (int i = 0; i < 9; i++) begin
      rd_en = 1'b1;
      step();
      if (i < 8) begin
        tests++; if (rd_ack !== 1'b1 || rd_err !== 1'b0) begin fails++; $display("FAIL drain_ack[%0d] got ack=%b err=%b exp ack=1 err=0", i, rd_ack, rd_err); end
        tests++; if (d_out !== 32'h00110011 * (i + 1)) begin fails++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, d_out, 32'h00110011 * (i + 1)); end
        tests++; if (data_count !== 4'(7 - i)) begin fails++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, data_count, 7 - i); end
      end else begin
        tests++; if (rd_ack !== 1'b0 || rd_err !== 1'b1) begin fails++; $display("FAIL drain_err got ack=%b err=%b exp ack=0 err=1", rd_ack, rd_err); end
        tests++; if (d_out !== 32'h00880088) begin fails++; $display("FAIL drain_hold got=%h exp=00880088", d_out); end
      end
    end
    idle();
    step();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty got=%b exp=1", empty); end
    tests++; if ({rd_ack, rd_err} !== 2'b00) begin fails++; $display("FAIL drain_idle_pulses got=%b exp=00", {rd_ack, rd_err}); end
  endtask

  task test_full_simul;
    logic [31:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      d_in  = 32'h00110011 * (i + 1);
      step();
    end
    wr_en = 1'b1;
    rd_en = 1'b1;
    d_in  = 32'h00aa00aa;
    step();
    tests++; if (rd_ack !== 1'b1 || wr_err !== 1'b1 || wr_ack !== 1'b0) begin fails++; $display("FAIL full_simul_hs got rd_ack=%b wr_err=%b wr_ack=%b exp 1 1 0", rd_ack, wr_err, wr_ack); end
    tests++; if (d_out !== 32'h00110011) begin fails++; $display("FAIL full_simul_dout got=%h exp=00110011", d_out); end
    tests++; if (data_count !== 4'd7) begin fails++; $display("FAIL full_simul_count got=%0d exp=7", data_count); end
    // Four concurrent read+write cycles, pushing 00a100a1..00a400a4.
    for (int i = 0; i < 4; i++) begin
      d_in = 32'h00a100a1 + 32'h00010001 * i;
      step();
      tests++; if (wr_ack !== 1'b1 || rd_ack !== 1'b1) begin fails++; $display("FAIL both_ack[%0d] got wr_ack=%b rd_ack=%b exp 1 1", i, wr_ack, rd_ack); end
      tests++; if (d_out !== 32'h00220022 + 32'h00110011 * i) begin fails++; $display("FAIL both_dout[%0d] got=%h exp=%h", i, d_out, 32'h00220022 + 32'h00110011 * i); end
      tests++; if (data_count !== 4'd7) begin fails++; $display("FAIL both_count[%0d] got=%0d exp=7", i, data_count); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      exp_d = (i < 3) ? 32'h00660066 + 32'h00110011 * i : 32'h00a100a1 + 32'h00010001 * (i - 3);
      tests++; if (d_out !== exp_d) begin fails++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, d_out, exp_d); end
    end
    idle();
    step();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task test_empty_simul;
    wr_en = 1'b1;
    rd_en = 1'b1;
    d_in  = 32'h00bb00bb;
    step();
    tests++; if (wr_ack !== 1'b1 || rd_err !== 1'b1 || rd_ack !== 1'b0) begin fails++; $display("FAIL empty_simul_hs got wr_ack=%b rd_err=%b rd_ack=%b exp 1 1 0", wr_ack, rd_err, rd_ack); end
    tests++; if (data_count !== 4'd1) begin fails++; $display("FAIL empty_simul_count got=%0d exp=1", data_count); end
    wr_en = 1'b0;
    step();
    tests++; if (rd_ack !== 1'b1 || d_out !== 32'h00bb00bb) begin fails++; $display("FAIL empty_simul_read got ack=%b d_out=%h exp ack=1 d_out=00bb00bb", rd_ack, d_out); end
    idle();
    step();
  endtask

  task test_flush;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      d_in  = 32'h01000000 + i;
      step();
    end
    flush = 1'b1;
    d_in  = 32'h0dead000;
    step();
    tests++; if (wr_err !== 1'b1 || wr_ack !== 1'b0) begin fails++; $display("FAIL flush_wr_err got err=%b ack=%b exp err=1 ack=0", wr_err, wr_ack); end
    tests++; if (data_count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL flush_count got cnt=%0d empty=%b exp cnt=0 empty=1", data_count, empty); end
    tests++; if (d_out !== 32'h00bb00bb) begin fails++; $display("FAIL flush_dout_hold got=%h exp=00bb00bb", d_out); end
    flush = 1'b0;
    d_in  = 32'h00cc00cc;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    flush = 1'b1;
    step();
    tests++; if (rd_err !== 1'b1 || rd_ack !== 1'b0 || d_out !== 32'h00bb00bb) begin fails++; $display("FAIL flush_rd_err got err=%b ack=%b d_out=%h exp 1 0 00bb00bb", rd_err, rd_ack, d_out); end
    flush = 1'b0;
    wr_en = 1'b1;
    rd_en = 1'b0;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    tests++; if (rd_ack !== 1'b1 || d_out !== 32'h00cc00cc) begin fails++; $display("FAIL flush_after_read got ack=%b d_out=%h exp ack=1 d_out=00cc00cc", rd_ack, d_out); end
    idle();
    step();
  endtask

  task test_async_reset;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      d_in  = 32'h00dd00dd + i;
      step();
    end
    rd_en = 1'b1;
    step();
    // Mid-cycle: 1 ns after the edge, next edge is 9 ns away.
    #2;
    reset = 1'b1;
    #1;
    tests++; if (data_count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL async_reset_flags got cnt=%0d empty=%b full=%b exp 0 1 0", data_count, empty, full); end
    tests++; if (d_out !== 32'h00000000) begin fails++; $display("FAIL async_reset_dout got=%h exp=00000000", d_out); end
    tests++; if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000) begin fails++; $display("FAIL async_reset_pulses got=%b exp=0000", {wr_ack, wr_err, rd_ack, rd_err}); end
    idle();
    step();
    reset = 1'b0;
    rd_en = 1'b1;
    step();
    tests++; if (rd_err !== 1'b1 || data_count !== 4'd0) begin fails++; $display("FAIL post_reset_read got err=%b cnt=%0d exp err=1 cnt=0", rd_err, data_count); end
    idle();
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    d_in  = '0;
    test_reset();
    test_fill();
    test_drain();
    test_full_simul();
    test_empty_simul();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
